sort_host: RTL and testbench

//  Host-side driver for the bubble-sort engine. Holds a word_size x N source buffer written by
//  the system, streams it into the sorter (Load), requests Sort, waits for Waiting, then drains
//  the result (Send) into a result buffer. It also checks that the result is non-decreasing and

---
 rtl/sort_host.sv | 208 ++++++++++++++++++++
 tb/tb_sort_host.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_host.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | sort_host: host-side driver that loads, sorts and drains the bubble sorter.  |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module sort_host #(
  parameter int word_size = 4,
  parameter int N         = 8,
  parameter int AW        = 3,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [word_size-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [word_size-1:0] rd_data,
  output logic                 host_busy,
  output logic                 done,
  output logic                 err_order,
  output logic                 err_timeout,
  output logic                 Load,
  output logic                 Sort,
  output logic                 Send,
  output logic [word_size-1:0] Data_in,
  input  logic                 Ready,
  input  logic                 Busy,
  input  logic                 Waiting,
  input  logic [word_size-1:0] Data_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_LOAD, S_SORT, S_WAIT_SORT, S_SEND, S_DRAIN, S_DONE, S_ERR
  } state_t;

  localparam logic [AW-1:0] c_last    = AW'(N - 1);
  localparam logic [8:0]    c_tmo_lim = 9'(TIMEOUT);

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d, cap_q, cap_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [RD_LAT-1:0]    strb_q, strb_d;
  logic [word_size-1:0] prev_q, prev_d, din_q, din_d;
  logic                 load_q, load_d, sort_q, sort_d, send_q, send_d;
  logic                 done_q, done_d, eo_q, eo_d, et_q, et_d;
  logic [word_size-1:0] src_q [N];
  logic [word_size-1:0] res_q [N];

  logic                 w_busy, w_cap, w_unused_busy;
  logic [RD_LAT:0]      w_strb_shift;
  logic [8:0]           w_tmo_inc;
  logic [AW-1:0]        w_idx_nxt;

  // The sorter's Busy is informational only; progress is gated on Waiting.
  assign w_unused_busy = Busy;

  assign w_busy       = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign w_cap        = strb_q[RD_LAT-1] && (state_q == S_SEND || state_q == S_DRAIN);
  assign w_strb_shift = {strb_q, send_q};
  assign w_tmo_inc    = {1'b0, tmo_q} + 9'd1;
  assign w_idx_nxt    = idx_q + AW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    tmo_d   = tmo_q;
    strb_d  = w_strb_shift[RD_LAT-1:0];
    prev_d  = prev_q;
    din_d   = '0;
    load_d  = 1'b0;
    sort_d  = 1'b0;
    send_d  = 1'b0;
    done_d  = done_q;
    eo_d    = eo_q;
    et_d    = et_q;

    if (w_cap) begin
      prev_d = Data_out;
      if (cap_q != '0 && Data_out < prev_q) eo_d = 1'b1;
      if (cap_q != c_last) cap_d = cap_q + AW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_WAIT_RDY;
          tmo_d   = '0;
          done_d  = 1'b0;
          eo_d    = 1'b0;
          et_d    = 1'b0;
        end
      end
      S_WAIT_RDY: begin
        if (Ready) begin
          state_d = S_LOAD;
          idx_d   = '0;
          load_d  = 1'b1;
          din_d   = src_q[0];
        end else begin
          if (tmo_q != 8'hFF) tmo_d = w_tmo_inc[7:0];
          if (w_tmo_inc >= c_tmo_lim) begin
            state_d = S_ERR;
            et_d    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (idx_q == c_last) begin
          state_d = S_SORT;
          sort_d  = 1'b1;
        end else begin
          idx_d  = w_idx_nxt;
          load_d = 1'b1;
          din_d  = src_q[w_idx_nxt];
        end
      end
      S_SORT: begin
        state_d = S_WAIT_SORT;
        tmo_d   = '0;
      end
      S_WAIT_SORT: begin
        if (Waiting) begin
          state_d = S_SEND;
          idx_d   = '0;
          cap_d   = '0;
          send_d  = 1'b1;
        end else begin
          if (tmo_q != 8'hFF) tmo_d = w_tmo_inc[7:0];
          if (w_tmo_inc >= c_tmo_lim) begin
            state_d = S_ERR;
            et_d    = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (idx_q == c_last) begin
          state_d = S_DRAIN;
        end else begin
          idx_d  = w_idx_nxt;
          send_d = 1'b1;
        end
      end
      S_DRAIN: begin
        // The final word arrives RD_LAT cycles after the last Send cycle.
        if (w_cap && cap_q == c_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cap_q   <= '0;
      tmo_q   <= '0;
      strb_q  <= '0;
      prev_q  <= '0;
      din_q   <= '0;
      load_q  <= 1'b0;
      sort_q  <= 1'b0;
      send_q  <= 1'b0;
      done_q  <= 1'b0;
      eo_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      tmo_q   <= tmo_d;
      strb_q  <= strb_d;
      prev_q  <= prev_d;
      din_q   <= din_d;
      load_q  <= load_d;
      sort_q  <= sort_d;
      send_q  <= send_d;
      done_q  <= done_d;
      eo_q    <= eo_d;
      et_q    <= et_d;
    end
  end

  // Buffers carry no reset so a job can be rerun after rst without rewriting src.
  always_ff @(posedge clk) begin
    if (wr_en && !w_busy) src_q[wr_addr] <= wr_data;
    if (w_cap) res_q[cap_q] <= Data_out;
  end

  assign rd_data     = res_q[rd_addr];
  assign host_busy   = w_busy;
  assign done        = done_q;
  assign err_order   = eo_q;
  assign err_timeout = et_q;
  assign Load        = load_q;
  assign Sort        = sort_q;
  assign Send        = send_q;
  assign Data_in     = din_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_host.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_sort_host: directed bench for sort_host with a behavioural sorter model.  |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module tb_sort_host;

  localparam int TMO = 255;

  logic       clk, rst, start, start3, wr_en, wr_en3;
  logic [2:0] wr_addr, rd_addr;
  logic [3:0] wr_data;
  logic       rdy, bsy, wtg;
  logic [3:0] rd_data, Data_in, Data_out;
  logic       host_busy, done, err_order, err_timeout, Load, Sort, Send;
  logic [3:0] rd_data3, Data_in3, Data_out3;
  logic       host_busy3, done3, err_order3, err_timeout3, Load3, Sort3, Send3;

  int n_chk = 0, n_pass = 0, excl_bad = 0;
  logic [31:0] exp_src;
  logic [3:0]  ret_tab [8];
  logic [2:0]  s_idx, p_idx;
  logic [2:0]  v3;

  sort_host #(.word_size(4), .N(8), .AW(3), .RD_LAT(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .host_busy(host_busy), .done(done),
    .err_order(err_order), .err_timeout(err_timeout), .Load(Load), .Sort(Sort), .Send(Send),
    .Data_in(Data_in), .Ready(rdy), .Busy(bsy), .Waiting(wtg), .Data_out(Data_out));

  sort_host #(.word_size(4), .N(8), .AW(3), .RD_LAT(3), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .wr_en(wr_en3), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data3), .host_busy(host_busy3), .done(done3),
    .err_order(err_order3), .err_timeout(err_timeout3), .Load(Load3), .Sort(Sort3), .Send(Send3),
    .Data_in(Data_in3), .Ready(rdy), .Busy(bsy), .Waiting(wtg), .Data_out(Data_out3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sorter model, latency 1: returns ret_tab[k] one cycle after Send cycle k.
  always @(posedge clk) begin
    if (Sort) s_idx <= 3'd0;
    else if (Send) s_idx <= s_idx + 3'd1;
    p_idx <= s_idx;
  end
  assign Data_out = ret_tab[p_idx];

  // Sorter model, latency 3: 0xF only in the cycle the word is due, 0 otherwise.
  always @(posedge clk) v3 <= {v3[1:0], Send3};
  assign Data_out3 = v3[2] ? 4'hF : 4'h0;

  always @(negedge clk) begin
    if (!rst && (int'(Load) + int'(Sort) + int'(Send) > 1)) excl_bad++;
    if (!rst && (int'(Load3) + int'(Sort3) + int'(Send3) > 1)) excl_bad++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_ret(input logic [31:0] v);
    for (int k = 0; k < 8; k++) ret_tab[k] = v[4*k +: 4];
  endtask

  task automatic write_src(input logic [31:0] v, input bit to3);
    for (int k = 0; k < 8; k++) begin
      wr_addr = 3'(k); wr_data = v[4*k +: 4];
      if (to3) wr_en3 = 1'b1; else wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0; wr_en3 = 1'b0;
  endtask

  // Drives a dut job up to WAIT_SORT; bad counts Load/Data_in/Sort deviations.
  task automatic job_start(input bit pulse, output int bad);
    int t;
    bad = 0; wtg = 1'b0; rdy = 1'b1; t = 0;
    if (pulse) begin start = 1'b1; step(); start = 1'b0; end
    while (Load !== 1'b1 && t < 20) begin step(); t++; end
    if (Load !== 1'b1) begin bad = 99; return; end
    for (int k = 0; k < 8; k++) begin
      if (Load !== 1'b1 || Data_in !== exp_src[4*k +: 4]) bad++;
      step();
    end
    if (Sort !== 1'b1 || Load !== 1'b0) bad++;
    step();
    if (Sort !== 1'b0) bad++;
  endtask

  // Releases Waiting; lat = cycles from first Send to done.
  task automatic job_finish(output int nsend, output int lat);
    int t;
    t = 0;
    bsy = 1'b1; step(); step(); bsy = 1'b0; wtg = 1'b1;
    while (Send !== 1'b1 && t < 20) begin step(); t++; end
    nsend = 0; lat = 0;
    if (Send !== 1'b1) begin nsend = -1; lat = -1; wtg = 1'b0; return; end
    while (done !== 1'b1 && lat < 40) begin
      if (Send === 1'b1) nsend++;
      step(); lat++;
    end
    wtg = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_chk++;
    if ({host_busy, done, err_order, err_timeout, Load, Sort, Send, Data_in} !== 11'd0)
      $display("FAIL reset_dut: got %b expected 0",
               {host_busy, done, err_order, err_timeout, Load, Sort, Send, Data_in});
    else n_pass++;
    n_chk++;
    if ({host_busy3, done3, err_order3, err_timeout3, Load3, Sort3, Send3, Data_in3} !== 11'd0)
      $display("FAIL reset_dut3: got %b expected 0",
               {host_busy3, done3, err_order3, err_timeout3, Load3, Sort3, Send3, Data_in3});
    else n_pass++;
  endtask

  task automatic test_sort();
    int bad, ns, lat;
    exp_src = 32'h0426_1537;
    write_src(exp_src, 1'b0);
    set_ret(32'h7654_3210);
    job_start(1'b1, bad);
    n_chk++; if (bad !== 0) $display("FAIL sort_load: got %0d bad cycles expected 0", bad); else n_pass++;
    job_finish(ns, lat);
    n_chk++; if (ns !== 8) $display("FAIL sort_send_len: got %0d expected 8", ns); else n_pass++;
    n_chk++; if (lat !== 9) $display("FAIL sort_done_lat: got %0d expected 9", lat); else n_pass++;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      if (rd_data !== 4'(k)) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL sort_result: got %0d wrong words expected 0", bad); else n_pass++;
    n_chk++;
    if ({done, err_order, host_busy} !== 3'b100)
      $display("FAIL sort_flags: got %b expected 100", {done, err_order, host_busy});
    else n_pass++;
  endtask

  task automatic test_order();
    int bad, ns, lat;
    set_ret(32'h7653_4210);
    job_start(1'b1, bad);
    job_finish(ns, lat);
    n_chk++;
    if ({done, err_order} !== 2'b11) $display("FAIL order_err: got %b expected 11", {done, err_order});
    else n_pass++;
    set_ret(32'h7654_3210);
    start = 1'b1; step(); start = 1'b0;
    n_chk++;
    if ({done, err_order, host_busy} !== 3'b001)
      $display("FAIL order_clear: got %b expected 001", {done, err_order, host_busy});
    else n_pass++;
    job_start(1'b0, bad);
    job_finish(ns, lat);
    n_chk++;
    if ({done, err_order, bad} !== {2'b10, 32'd0})
      $display("FAIL order_rerun: got done=%b err=%b bad=%0d expected 1 0 0", done, err_order, bad);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit seen = 1'b0;
    rdy = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i < TMO; i++) begin step(); if (Load === 1'b1) seen = 1'b1; end
    n_chk++;
    if (err_timeout !== 1'b0) $display("FAIL tmo_early: got %b expected 0", err_timeout); else n_pass++;
    step(); if (Load === 1'b1) seen = 1'b1;
    n_chk++;
    if ({err_timeout, host_busy, done} !== 3'b100)
      $display("FAIL tmo_err: got %b expected 100", {err_timeout, host_busy, done});
    else n_pass++;
    n_chk++; if (seen !== 1'b0) $display("FAIL tmo_load: got %b expected 0", seen); else n_pass++;
  endtask

  task automatic test_lat3();
    int t = 0, lat = 0, bad = 0;
    write_src(32'hFFFF_FFFF, 1'b1);
    rdy = 1'b1; wtg = 1'b0;
    start3 = 1'b1; step(); start3 = 1'b0;
    while (Sort3 !== 1'b1 && t < 30) begin step(); t++; end
    step(); wtg = 1'b1; t = 0;
    while (Send3 !== 1'b1 && t < 20) begin step(); t++; end
    while (done3 !== 1'b1 && lat < 40) begin step(); lat++; end
    wtg = 1'b0;
    n_chk++; if (lat !== 11) $display("FAIL lat3_done: got %0d expected 11", lat); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k); #1;
      if (rd_data3 !== 4'hF) bad++;
    end
    n_chk++; if (bad !== 0) $display("FAIL lat3_result: got %0d wrong words expected 0", bad); else n_pass++;
    n_chk++; if (err_order3 !== 1'b0) $display("FAIL lat3_order: got %b expected 0", err_order3); else n_pass++;
  endtask

  task automatic test_rst_mid();
    int t = 0, bad, ns, lat;
    rdy = 1'b1; wtg = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    while (Load !== 1'b1 && t < 20) begin step(); t++; end
    step(); step(); step();
    rst = 1'b1; step();
    n_chk++;
    if ({Load, host_busy} !== 2'b00) $display("FAIL rst_mid: got %b expected 00", {Load, host_busy});
    else n_pass++;
    rst = 1'b0; step();
    job_start(1'b1, bad);
    job_finish(ns, lat);
    n_chk++;
    if ({done, bad} !== {1'b1, 32'd0})
      $display("FAIL rst_restart: got done=%b bad=%0d expected 1 0", done, bad);
    else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int bad, ns, lat;
    job_start(1'b1, bad);
    start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
    step();
    start = 1'b0; wr_en = 1'b0;
    step();
    n_chk++;
    if ({Load, Send, host_busy} !== 3'b001)
      $display("FAIL busy_restart: got %b expected 001", {Load, Send, host_busy});
    else n_pass++;
    job_finish(ns, lat);
    n_chk++;
    if ({done, ns} !== {1'b1, 32'd8}) $display("FAIL busy_done: got done=%b ns=%0d expected 1 8", done, ns);
    else n_pass++;
    job_start(1'b1, bad);
    job_finish(ns, lat);
    n_chk++; if (bad !== 0) $display("FAIL busy_src: got %0d bad cycles expected 0", bad); else n_pass++;
  endtask

  task automatic test_exclusive();
    n_chk++; if (excl_bad !== 0) $display("FAIL strobe_excl: got %0d expected 0", excl_bad); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start3 = 1'b0; wr_en = 1'b0; wr_en3 = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0; rdy = 1'b0; bsy = 1'b0; wtg = 1'b0;
    exp_src = '0;
    set_ret(32'h7654_3210);
    test_reset();
    test_sort();
    test_order();
    test_timeout();
    test_lat3();
    test_rst_mid();
    test_busy_ignore();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
